// File: rtl/cpu_mc_pkg.sv
// cpu_mc_pkg: shared constants for the multi-cycle accumulator CPU.
// Contents: FSM state codes, ALU op codes, opcode constants, flag bit
// indices and a decode helper for opcodes that carry an immediate.
package cpu_mc_pkg;

  // FSM state encoding
  localparam logic [2:0] S_FETCH = 3'd0;
  localparam logic [2:0] S_IMM0  = 3'd1;
  localparam logic [2:0] S_IMM1  = 3'd2;
  localparam logic [2:0] S_MEM   = 3'd3;
  localparam logic [2:0] S_EXEC  = 3'd4;
  localparam logic [2:0] S_HALT  = 3'd5;

  // ALU operations: 0..7 mirror op[6:4] of the ALU group, 8..11 are unary on A
  localparam logic [3:0] ALU_MOV  = 4'd0;
  localparam logic [3:0] ALU_AND  = 4'd1;
  localparam logic [3:0] ALU_OR   = 4'd2;
  localparam logic [3:0] ALU_XOR  = 4'd3;
  localparam logic [3:0] ALU_ADD  = 4'd4;
  localparam logic [3:0] ALU_ADC  = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_SBC  = 4'd7;
  localparam logic [3:0] ALU_INC  = 4'd8;
  localparam logic [3:0] ALU_DEC  = 4'd9;
  localparam logic [3:0] ALU_SWAP = 4'd10;
  localparam logic [3:0] ALU_REV  = 4'd11;

  // Opcodes
  localparam logic [7:0] OP_LDI  = 8'h90;
  localparam logic [7:0] OP_LD   = 8'hA0;
  localparam logic [7:0] OP_ST   = 8'hB0;
  localparam logic [7:0] OP_JP   = 8'hF0;
  localparam logic [7:0] OP_JZ   = 8'hF1;
  localparam logic [7:0] OP_JNZ  = 8'hF2;
  localparam logic [7:0] OP_JC   = 8'hF3;
  localparam logic [7:0] OP_JNC  = 8'hF4;
  localparam logic [7:0] OP_HALT = 8'hFF;

  // Bit positions in the {Z,N,C} flag vector
  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_Z = 2;

  // Opcodes that read at least one immediate word after the opcode
  function automatic logic is_imm_op(input logic [7:0] op);
    case (op)
      OP_LDI, OP_LD, OP_ST, OP_JP, OP_JZ, OP_JNZ, OP_JC, OP_JNC: is_imm_op = 1'b1;
      default:                                                   is_imm_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_mc_alu.sv
// cpu_mc_alu: combinational ALU for cpu_mc.
// Ports: op (ALU_* code), src1/src2 operands, c_in (current carry),
//        result, flags ({Z,N,C}); C passes through for ops that keep it.
module cpu_mc_alu
  import cpu_mc_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic              c_in,
  output logic [DATA_W-1:0] result,
  output logic [2:0]        flags
);

  localparam int unsigned EXT_W = DATA_W + 1;

  logic [EXT_W-1:0] ext1;
  logic [EXT_W-1:0] ext2;
  logic [EXT_W-1:0] cin_ext;
  logic [EXT_W-1:0] bin_ext;
  logic [EXT_W-1:0] wide;
  logic             c_out;

  // Operate on DATA_W+1 bits so the top bit is carry (add) or borrow (sub)
  always_comb begin
    ext1    = {1'b0, src1};
    ext2    = {1'b0, src2};
    cin_ext = {{DATA_W{1'b0}}, c_in};
    bin_ext = {{DATA_W{1'b0}}, ~c_in};
    wide    = '0;
    c_out   = c_in;
    case (op)
      ALU_MOV: wide = ext2;
      ALU_AND: wide = ext1 & ext2;
      ALU_OR:  wide = ext1 | ext2;
      ALU_XOR: wide = ext1 ^ ext2;
      ALU_ADD: begin wide = ext1 + ext2;           c_out = wide[DATA_W];  end
      ALU_ADC: begin wide = ext1 + ext2 + cin_ext; c_out = wide[DATA_W];  end
      ALU_SUB: begin wide = ext1 - ext2;           c_out = ~wide[DATA_W]; end
      ALU_SBC: begin wide = ext1 - ext2 - bin_ext; c_out = ~wide[DATA_W]; end
      ALU_INC: wide = ext1 + EXT_W'(1);
      ALU_DEC: wide = ext1 - EXT_W'(1);
      ALU_SWAP: wide = {1'b0, src1[DATA_W/2-1:0], src1[DATA_W-1:DATA_W/2]};
      ALU_REV: begin
        for (int i = 0; i < DATA_W; i++) wide[i] = src1[DATA_W-1-i];
      end
      default: wide = '0;
    endcase
    result        = wide[DATA_W-1:0];
    flags[FLAG_Z] = (wide[DATA_W-1:0] == '0);
    flags[FLAG_N] = wide[DATA_W-1];
    flags[FLAG_C] = c_out;
  end

endmodule

// File: rtl/cpu_mc.sv
// cpu_mc: multi-cycle accumulator CPU, sole master of one memory port.
// Ports: clk, reset_n (async, active low); memory port mem_addr_out,
//        mem_data_out, mem_read, mem_write, mem_data_in, mem_done;
//        debug pc_out, flags_out ({Z,N,C}), halted.
// Optional feature: CPU_HALT_EN makes opcode 0xFF halt the core.
module cpu_mc
  import cpu_mc_pkg::*;
#(
  parameter int unsigned       DATA_W   = 8,
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic [DATA_W-1:0] mem_data_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic              mem_read,
  output logic              mem_write,
  input  logic              mem_done,
  output logic [ADDR_W-1:0] pc_out,
  output logic [2:0]        flags_out,
  output logic              halted
);

  logic [2:0]        state_q, state_nx;
  logic [ADDR_W-1:0] pc_q, pc_nx;
  logic [7:0]        ir_q, ir_nx;
  logic [DATA_W-1:0] imm0_q, imm0_nx, imm1_q, imm1_nx;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] regs [8];
  logic [2:0]        flags_q;
  logic              rd_q, wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [ADDR_W-1:0] imm_addr_nx;
  logic [DATA_W-1:0] rx_val;
  logic              rd_done, is_mem, is_unary, jump_taken;
  logic              a_we, r_we, f_we;
  logic [3:0]        alu_op;
  logic [DATA_W-1:0] alu_src1, alu_src2, alu_res;
  logic [2:0]        alu_flags;

  assign rx_val   = regs[ir_q[2:0]];
  assign rd_done  = rd_q && mem_done;
  assign is_mem   = (ir_q == OP_LD) || (ir_q == OP_ST);
  assign is_unary = (ir_q[7:2] == 6'b100000);
  // Wide data buses carry the whole address in IMM0
  assign imm_addr_nx = (DATA_W == 8) ? ADDR_W'({imm1_nx, imm0_nx}) : ADDR_W'(imm0_nx);

  // Jump condition from the current flags
  always_comb begin
    case (ir_q)
      OP_JP:   jump_taken = 1'b1;
      OP_JZ:   jump_taken = flags_q[FLAG_Z];
      OP_JNZ:  jump_taken = ~flags_q[FLAG_Z];
      OP_JC:   jump_taken = flags_q[FLAG_C];
      OP_JNC:  jump_taken = ~flags_q[FLAG_C];
      default: jump_taken = 1'b0;
    endcase
  end

  // ALU operand select; loads reuse MOV so they set Z/N and keep C
  always_comb begin
    alu_op   = ALU_MOV;
    alu_src1 = a_q;
    alu_src2 = rx_val;
    if (state_q == S_MEM) begin
      alu_src2 = mem_data_in;
    end else if (ir_q == OP_LDI) begin
      alu_src2 = imm0_q;
    end else if (is_unary) begin
      alu_op = {2'b10, ir_q[1:0]};
    end else if (!ir_q[7]) begin
      alu_op = {1'b0, ir_q[6:4]};
      if (ir_q[3]) begin
        alu_src1 = rx_val;
        alu_src2 = a_q;
      end
    end
  end

  cpu_mc_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (alu_op),
    .src1   (alu_src1),
    .src2   (alu_src2),
    .c_in   (flags_q[FLAG_C]),
    .result (alu_res),
    .flags  (alu_flags)
  );

  // Next-state, PC and write-enable logic
  always_comb begin
    state_nx = state_q;
    pc_nx    = pc_q;
    ir_nx    = ir_q;
    imm0_nx  = imm0_q;
    imm1_nx  = imm1_q;
    a_we     = 1'b0;
    r_we     = 1'b0;
    f_we     = 1'b0;
    case (state_q)
      S_FETCH: if (rd_done) begin
        pc_nx = pc_q + ADDR_W'(1);
        ir_nx = mem_data_in[7:0];
        if (is_imm_op(mem_data_in[7:0])) state_nx = S_IMM0;
`ifdef CPU_HALT_EN
        else if (mem_data_in[7:0] == OP_HALT) state_nx = S_HALT;
`endif
        else state_nx = S_EXEC;
      end
      S_IMM0: if (rd_done) begin
        pc_nx   = pc_q + ADDR_W'(1);
        imm0_nx = mem_data_in;
        if (ir_q == OP_LDI)  state_nx = S_EXEC;
        else if (DATA_W > 8) state_nx = is_mem ? S_MEM : S_EXEC;
        else                 state_nx = S_IMM1;
      end
      S_IMM1: if (rd_done) begin
        pc_nx    = pc_q + ADDR_W'(1);
        imm1_nx  = mem_data_in;
        state_nx = is_mem ? S_MEM : S_EXEC;
      end
      S_MEM: if ((rd_q || wr_q) && mem_done) begin
        a_we     = (ir_q == OP_LD);
        f_we     = (ir_q == OP_LD);
        state_nx = S_FETCH;
      end
      S_EXEC: begin
        state_nx = S_FETCH;
        if (!ir_q[7]) begin
          f_we = 1'b1;
          r_we = ir_q[3];
          a_we = ~ir_q[3];
        end else if (is_unary || ir_q == OP_LDI) begin
          a_we = 1'b1;
          f_we = 1'b1;
        end else if (jump_taken) begin
          pc_nx = imm_addr_nx;
        end
      end
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_FETCH;
    endcase
  end

  // Registered bus outputs decoded from the next state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      imm0_q  <= '0;
      imm1_q  <= '0;
      a_q     <= '0;
      flags_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= RESET_PC;
      wdata_q <= '0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      state_q <= state_nx;
      pc_q    <= pc_nx;
      ir_q    <= ir_nx;
      imm0_q  <= imm0_nx;
      imm1_q  <= imm1_nx;
      if (a_we) a_q <= alu_res;
      if (r_we) regs[ir_q[2:0]] <= alu_res;
      if (f_we) flags_q <= alu_flags;
      rd_q    <= (state_nx == S_FETCH) || (state_nx == S_IMM0) || (state_nx == S_IMM1) ||
                 ((state_nx == S_MEM) && (ir_nx == OP_LD));
      wr_q    <= (state_nx == S_MEM) && (ir_nx == OP_ST);
      addr_q  <= (state_nx == S_MEM) ? imm_addr_nx : pc_nx;
      wdata_q <= a_q;
    end
  end

`ifdef CPU_HALT_EN
  logic halted_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) halted_q <= 1'b0;
    else          halted_q <= (state_nx == S_HALT);
  end
  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  assign mem_read     = rd_q;
  assign mem_write    = wr_q;
  assign mem_addr_out = addr_q;
  assign mem_data_out = wdata_q;
  assign pc_out       = pc_q;
  assign flags_out    = flags_q;

endmodule

// File: tb/tb_cpu_mc.sv
// tb_cpu_mc: self-checking bench for cpu_mc with a wait-state memory model.
module tb_cpu_mc;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  mem_data_in = '0;
  logic [7:0]  mem_data_out;
  logic [15:0] mem_addr_out;
  logic        mem_read, mem_write;
  logic        mem_done = 1'b0;
  logic [15:0] pc_out;
  logic [2:0]  flags_out;
  logic        halted;

  cpu_mc #(.DATA_W(8), .ADDR_W(16), .RESET_PC(16'h0100)) dut (
    .clk(clk), .reset_n(reset_n), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .mem_addr_out(mem_addr_out), .mem_read(mem_read), .mem_write(mem_write),
    .mem_done(mem_done), .pc_out(pc_out), .flags_out(flags_out), .halted(halted)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [0:65535];
  logic [7:0]  prog [$];
  int          wait_cfg = 0;
  int          checks = 0;
  int          errors = 0;

  // Written only by the memory responder
  int          wcnt = 0;
  int          overlap_n = 0;
  int          unstable_n = 0;
  logic        hold_prev = 1'b0;
  logic [15:0] prev_addr = '0;
  logic [15:0] rd_log [$];
  logic [15:0] wr_addr_log [$];
  logic [7:0]  wr_data_log [$];
  logic [2:0]  wr_flag_log [$];

  int rd_base, wr_base, ov_base, un_base;

  // Memory responder: drives mem_done for the coming rising edge after wait_cfg wait cycles
  always @(negedge clk) begin
    if (!reset_n || !(mem_read || mem_write)) begin
      mem_done  = 1'b0;
      wcnt      = 0;
      hold_prev = 1'b0;
    end else begin
      if (mem_read && mem_write) overlap_n++;
      if (hold_prev && mem_addr_out != prev_addr) unstable_n++;
      if (mem_done) wcnt = 0;
      if (wcnt >= wait_cfg) begin
        mem_done = 1'b1;
        if (mem_read) begin
          mem_data_in = mem[mem_addr_out];
          rd_log.push_back(mem_addr_out);
        end else begin
          wr_addr_log.push_back(mem_addr_out);
          wr_data_log.push_back(mem_data_out);
          wr_flag_log.push_back(flags_out);
        end
      end else begin
        mem_done = 1'b0;
        wcnt++;
      end
      hold_prev = !mem_done;
      prev_addr = mem_addr_out;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic put(input logic [7:0] b);
    prog.push_back(b);
  endtask

  // Load prog at 0x0100 over a NOP-filled page, then reset and release
  task automatic load_and_reset();
    reset_n = 1'b0;
    for (int i = 16'h0100; i < 16'h0200; i++) mem[i] = 8'hEE;
    for (int i = 0; i < prog.size(); i++) mem[16'h0100 + i] = prog[i];
    prog.delete();
    repeat (2) @(negedge clk);
    rd_base = rd_log.size();
    wr_base = wr_addr_log.size();
    ov_base = overlap_n;
    un_base = unstable_n;
    reset_n = 1'b1;
  endtask

  task automatic wait_writes(input int n, input int budget, input string name);
    int k;
    k = 0;
    while ((wr_addr_log.size() - wr_base) < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({name, "_wr_seen"}, 32'(wr_addr_log.size() - wr_base >= n), 32'd1);
  endtask

  task automatic wait_reads(input int n, input int budget, input string name);
    int k;
    k = 0;
    while ((rd_log.size() - rd_base) < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({name, "_rd_seen"}, 32'(rd_log.size() - rd_base >= n), 32'd1);
  endtask

  typedef struct {
    logic [7:0] x, y;
    logic       cin;
    logic [7:0] op, op2;
    logic [7:0] res;
    logic [2:0] flg;
  } vec_t;

  vec_t vecs [15];

  initial begin
    int cyc, hold, reqs;

    for (int i = 0; i < 65536; i++) mem[i] = 8'hEE;
    mem[16'h1234] = 8'h77;

    // A=x, R1=y, optional C=1 preset; flags listed as {Z,N,C}
    vecs[0]  = '{x:8'h80, y:8'h80, cin:1'b0, op:8'h41, op2:8'hEE, res:8'h00, flg:3'b101};
    vecs[1]  = '{x:8'h10, y:8'h20, cin:1'b1, op:8'h51, op2:8'hEE, res:8'h31, flg:3'b000};
    vecs[2]  = '{x:8'h05, y:8'h07, cin:1'b0, op:8'h61, op2:8'hEE, res:8'hFE, flg:3'b010};
    vecs[3]  = '{x:8'h05, y:8'h03, cin:1'b0, op:8'h71, op2:8'hEE, res:8'h01, flg:3'b001};
    vecs[4]  = '{x:8'h05, y:8'h03, cin:1'b1, op:8'h71, op2:8'hEE, res:8'h02, flg:3'b001};
    vecs[5]  = '{x:8'hF0, y:8'h3C, cin:1'b0, op:8'h11, op2:8'hEE, res:8'h30, flg:3'b000};
    vecs[6]  = '{x:8'hF0, y:8'h0F, cin:1'b1, op:8'h21, op2:8'hEE, res:8'hFF, flg:3'b011};
    vecs[7]  = '{x:8'hAA, y:8'hAA, cin:1'b0, op:8'h31, op2:8'hEE, res:8'h00, flg:3'b100};
    vecs[8]  = '{x:8'h12, y:8'h80, cin:1'b0, op:8'h01, op2:8'hEE, res:8'h80, flg:3'b010};
    vecs[9]  = '{x:8'hFF, y:8'h01, cin:1'b1, op:8'h80, op2:8'hEE, res:8'h00, flg:3'b101};
    vecs[10] = '{x:8'h00, y:8'h01, cin:1'b0, op:8'h81, op2:8'hEE, res:8'hFF, flg:3'b010};
    vecs[11] = '{x:8'h1E, y:8'h01, cin:1'b0, op:8'h82, op2:8'hEE, res:8'hE1, flg:3'b010};
    vecs[12] = '{x:8'h01, y:8'h01, cin:1'b0, op:8'h83, op2:8'hEE, res:8'h80, flg:3'b010};
    vecs[13] = '{x:8'h03, y:8'h10, cin:1'b0, op:8'h69, op2:8'h01, res:8'h0D, flg:3'b001};
    vecs[14] = '{x:8'h00, y:8'h55, cin:1'b0, op:8'hEE, op2:8'hEE, res:8'h00, flg:3'b100};

    // Reset in the middle of a wait-stated LD, then the LD timing itself
    put(8'hA0); put(8'h34); put(8'h12); put(8'hB0); put(8'h00); put(8'h30);
    wait_cfg = 3;
    load_and_reset();
    repeat (7) @(negedge clk);
    check("busy_before_reset", 32'(mem_read), 32'd1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_pc", 32'(pc_out), 32'h0100);
    check("rst_flags", 32'(flags_out), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    @(negedge clk);
    rd_base = rd_log.size();
    wr_base = wr_addr_log.size();
    reset_n = 1'b1;
    check("rel_mem_read_low", 32'(mem_read), 32'd0);
    @(negedge clk);
    check("first_read", 32'(mem_read), 32'd1);
    check("first_addr", 32'(mem_addr_out), 32'h0100);
    cyc  = 1;
    hold = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (mem_read && mem_addr_out == 16'h0103) break;
      if (mem_read || mem_write) cyc++;
      if (mem_read && mem_addr_out == 16'h1234) hold++;
    end
    check("ld_wait_cycles", 32'(cyc), 32'd16);
    check("ld_addr_hold", 32'(hold), 32'd4);
    wait_writes(1, 100, "ld");
    check("ld_value", 32'(wr_data_log[wr_base]), 32'h77);
    check("ld_flags", 32'(wr_flag_log[wr_base]), 32'b000);
    wait_cfg = 0;

    // Table-driven ALU/unary vectors, result observed through ST [0x3000]
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].cin) begin put(8'h90); put(8'hFF); put(8'h0A); put(8'h42); end
      put(8'h90); put(vecs[i].y); put(8'h09); put(8'h90); put(vecs[i].x);
      put(vecs[i].op); put(vecs[i].op2); put(8'hB0); put(8'h00); put(8'h30);
      load_and_reset();
      wait_writes(1, 200, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_addr", i), 32'(wr_addr_log[wr_base]), 32'h3000);
      check($sformatf("vec%0d_res", i), 32'(wr_data_log[wr_base]), 32'(vecs[i].res));
      check($sformatf("vec%0d_flags", i), 32'(wr_flag_log[wr_base]), 32'(vecs[i].flg));
    end

    // LDI FF; MOV R3,A; INC A; ADD A,R3; ST; SUB A,R3; ST
    put(8'h90); put(8'hFF); put(8'h0B); put(8'h80); put(8'h43);
    put(8'hB0); put(8'h00); put(8'h30); put(8'h63); put(8'hB0); put(8'h01); put(8'h30);
    load_and_reset();
    wait_writes(2, 200, "arith");
    check("arith_add_a", 32'(wr_data_log[wr_base]), 32'hFF);
    check("arith_add_flags", 32'(wr_flag_log[wr_base]), 32'b010);
    check("arith_sub_a", 32'(wr_data_log[wr_base+1]), 32'h00);
    check("arith_sub_flags", 32'(wr_flag_log[wr_base+1]), 32'b101);

    // Single store with wait states, followed by a jump-to-self loop
    put(8'h90); put(8'h5A); put(8'hB0); put(8'h00); put(8'h20);
    put(8'hF0); put(8'h05); put(8'h01);
    wait_cfg = 2;
    load_and_reset();
    repeat (80) @(negedge clk);
    check("st_count", 32'(wr_addr_log.size() - wr_base), 32'd1);
    check("st_addr", 32'(wr_addr_log[wr_base]), 32'h2000);
    check("st_data", 32'(wr_data_log[wr_base]), 32'h5A);
    check("st_overlap", 32'(overlap_n - ov_base), 32'd0);
    check("st_stable", 32'(unstable_n - un_base), 32'd0);
    wait_cfg = 0;

    // Conditional jumps: index of the read that follows the jump
    put(8'h90); put(8'h00); put(8'hF1); put(8'h40); put(8'h00);
    load_and_reset();
    wait_reads(6, 100, "jz_taken");
    check("jz_taken_target", 32'(rd_log[rd_base+5]), 32'h0040);

    put(8'h90); put(8'h01); put(8'hF1); put(8'h40); put(8'h00);
    load_and_reset();
    wait_reads(6, 100, "jz_not");
    check("jz_not_target", 32'(rd_log[rd_base+5]), 32'h0105);

    put(8'h90); put(8'h80); put(8'h0A); put(8'h42); put(8'hF4); put(8'h40); put(8'h00);
    load_and_reset();
    wait_reads(8, 100, "jnc_not");
    check("jnc_not_target", 32'(rd_log[rd_base+7]), 32'h0107);

    put(8'h90); put(8'h80); put(8'h0A); put(8'h42); put(8'hF3); put(8'h40); put(8'h00);
    load_and_reset();
    wait_reads(8, 100, "jc_taken");
    check("jc_taken_target", 32'(rd_log[rd_base+7]), 32'h0040);

    // Opcode 0xFF
    put(8'h90); put(8'h12); put(8'hFF); put(8'h90); put(8'h34);
    put(8'hB0); put(8'h00); put(8'h30);
    load_and_reset();
`ifdef CPU_HALT_EN
    cyc = 0;
    while (!halted && cyc < 50) begin @(negedge clk); cyc++; end
    check("halt_flag", 32'(halted), 32'd1);
    reqs = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (mem_read || mem_write) reqs++;
    end
    check("halt_no_requests", 32'(reqs), 32'd0);
    check("halt_pc", 32'(pc_out), 32'h0103);
    check("halt_no_writes", 32'(wr_addr_log.size() - wr_base), 32'd0);
`else
    wait_writes(1, 100, "ff_nop");
    check("ff_next_fetch", 32'(rd_log[rd_base+3]), 32'h0103);
    check("ff_store", 32'(wr_data_log[wr_base]), 32'h34);
    check("ff_halted", 32'(halted), 32'd0);
    reqs = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
